// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_addr_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fsm_e;

  // Address that is in flight to decode, with its liveness flag.
  typedef struct packed {
    logic       valid;
    word_addr_t pc;
  } fetch_slot_t;

  localparam word_addr_t       RESET_PC_DEFAULT  = word_addr_t'(0);
  localparam logic [XLEN-1:0]  HALT_WORD_DEFAULT = XLEN'(0);

endpackage

// File: rtl/if_pc_reg.sv
// Fetch address register and in-flight slot with redirect/stall/advance mux.
module if_pc_reg
  import if_stage_pkg::*;
#(
  parameter word_addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect,
  input  word_addr_t  redirect_pc,
  input  logic        halt_take,
  output word_addr_t  pc_q,
  output fetch_slot_t slot_q
);

  word_addr_t  pc_d;
  fetch_slot_t slot_d;

  // Redirect beats stall; a halting word leaves an empty slot behind it.
  always_comb begin
    pc_d   = pc_q;
    slot_d = slot_q;
    if (run) begin
      if (redirect) begin
        pc_d         = redirect_pc;
        slot_d.pc    = pc_q;
        slot_d.valid = 1'b0;
      end else if (!stall) begin
        pc_d         = pc_q + word_addr_t'(1);
        slot_d.pc    = pc_q;
        slot_d.valid = !halt_take;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      slot_q.pc    <= RESET_PC;
      slot_q.valid <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives a 1-cycle synchronous imem, hands words to decode, halts on HALT_WORD.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  fsm_e        fsm_q, fsm_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  word_addr_t  pc_q;
  fetch_slot_t slot_q;
  logic        run, accept, halt_take;

  assign run       = (fsm_q == ST_RUN);
  assign id_valid  = slot_q.valid && run;
  assign accept    = id_valid && !id_stall && !redirect;
  assign halt_take = accept && (imem_instr == HALT_WORD);

  // During a stall the memory re-reads the held address so id_instr stays put.
  assign imem_addr = (run && id_stall && !redirect) ? slot_q.pc : pc_q;
  assign id_instr  = imem_instr;
  assign id_pc     = slot_q.pc;
  assign halted    = (fsm_q == ST_HALT);
  assign fetch_cnt = fetch_cnt_q;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .stall       (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_take   (halt_take),
    .pc_q        (pc_q),
    .slot_q      (slot_q)
  );

  always_comb begin
    fsm_d       = fsm_q;
    fetch_cnt_d = fetch_cnt_q;
    case (fsm_q)
      ST_RUN: begin
        if (accept)    fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (halt_take) fsm_d       = ST_HALT;
      end
      ST_HALT: fsm_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_RUN;
      fetch_cnt_q <= 32'd0;
    end else begin
      fsm_q       <= fsm_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        id_stall, redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, halted;
  logic [31:0] id_instr, id_pc, fetch_cnt;

  logic [31:0] w_addr, w_instr, w_instr_o, w_pc, w_cnt, w_rpc;
  logic        w_valid, w_halted, w_stall, w_redirect;

  logic [31:0] mem [64];
  logic [31:0] hi_word;

  int checks = 0;
  int errors = 0;

  // Reference model: next address to fetch, the slot handed to decode, halt flag, count.
  logic [31:0] m_next, m_slot_pc, m_cnt;
  logic        m_slot_v, m_halted;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'd0), .HALT_WORD(32'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFF), .HALT_WORD(32'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_instr(w_instr),
    .id_stall(w_stall), .redirect(w_redirect), .redirect_pc(w_rpc),
    .id_valid(w_valid), .id_instr(w_instr_o), .id_pc(w_pc),
    .halted(w_halted), .fetch_cnt(w_cnt)
  );

  // Instruction memory: 64 words at 0, one word at the top address, zero elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd64) return mem[a[5:0]];
    if (a == 32'hFFFF_FFFF) return hi_word;
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    imem_instr <= mem_word(imem_addr);
    w_instr    <= mem_word(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next = 32'd0; m_slot_pc = 32'd0; m_slot_v = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rp);
    logic [31:0] w;
    logic        live;
    if (m_halted) return;
    w    = mem_word(m_slot_pc);
    live = m_slot_v;
    if (rd) begin
      m_slot_pc = m_next; m_slot_v = 1'b0; m_next = rp;
    end else if (!st) begin
      if (live) m_cnt = m_cnt + 32'd1;
      if (live && w == 32'd0) m_halted = 1'b1;
      m_slot_pc = m_next;
      m_slot_v  = !(live && w == 32'd0);
      m_next    = m_next + 32'd1;
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = m_slot_v && !m_halted;
    chk("halted", 32'(halted), 32'(m_halted));
    chk("id_valid", 32'(id_valid), 32'(exp_v));
    chk("fetch_cnt", fetch_cnt, m_cnt);
    if (!m_halted)
      chk("imem_addr", imem_addr, (id_stall && !redirect) ? m_slot_pc : m_next);
    if (exp_v) begin
      chk("id_pc", id_pc, m_slot_pc);
      chk("id_instr", id_instr, mem_word(m_slot_pc));
    end
  endtask

  // One clock: drive at negedge, check, let the edge happen, advance model, settle.
  task automatic do_cycle(input logic r, input logic st, input logic rd, input logic [31:0] rp);
    @(negedge clk);
    rst_n = r; id_stall = st; redirect = rd; redirect_pc = rp;
    if (!r) model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    if (r) model_step(st, rd, rp);
    #1;
  endtask

  initial begin
    logic [31:0] held_instr, held_cnt;
    int          halt_cycles;

    rst_n = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    w_stall = 1'b0; w_redirect = 1'b0; w_rpc = 32'd0;
    hi_word = 32'hCAFE_0001;
    for (int i = 0; i < 64; i++) begin
      if (i == 4)       mem[i] = 32'd0;
      else if (i < 48)  mem[i] = 32'h1000_0000 | 32'(i);
      else              mem[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'h1);
    end
    model_reset();

    // Reset values
    do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFF);

    // Free run from reset to the halt word at address 4; wrap instance alongside
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk("run_id_pc", id_pc, 32'(k));
      chk("run_id_valid", 32'(id_valid), 32'd1);
      chk("run_halted", 32'(halted), 32'd0);
      if (k == 0) begin
        chk("wrap_pc0", w_pc, 32'hFFFF_FFFF);
        chk("wrap_instr0", w_instr_o, hi_word);
        chk("wrap_cnt0", w_cnt, 32'd0);
      end
      if (k == 1) begin
        chk("wrap_pc1", w_pc, 32'd0);
        chk("wrap_valid1", 32'(w_valid), 32'd1);
        chk("wrap_cnt1", w_cnt, 32'd1);
        chk("wrap_halted1", 32'(w_halted), 32'd0);
      end
    end
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("halt_rise", 32'(halted), 32'd1);
    chk("halt_cnt", fetch_cnt, 32'd5);
    do_cycle(1'b1, 1'b1, 1'b1, 32'd3);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_valid", 32'(id_valid), 32'd0);

    // Reset out of HALT, then stall for 3 cycles at id_pc=2
    do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_from_halt", 32'(halted), 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("pre_stall_pc", id_pc, 32'd2);
    held_instr = id_instr;
    held_cnt   = fetch_cnt;
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      chk("stall_pc", id_pc, 32'd2);
      chk("stall_instr", id_instr, held_instr);
      chk("stall_cnt", fetch_cnt, held_cnt);
    end
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("post_stall_pc", id_pc, 32'd3);
    chk("post_stall_cnt", fetch_cnt, 32'd3);

    // Redirect at id_pc=3 to 10; word 4 is the wrong path
    do_cycle(1'b1, 1'b0, 1'b1, 32'd10);
    chk("redir_bubble", 32'(id_valid), 32'd0);
    chk("redir_cnt", fetch_cnt, 32'd3);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("redir_pc", id_pc, 32'd10);
    chk("redir_valid", 32'(id_valid), 32'd1);
    chk("redir_no_halt", 32'(halted), 32'd0);

    // Redirect together with stall, then back-to-back redirects
    do_cycle(1'b1, 1'b1, 1'b1, 32'd20);
    chk("rs_bubble", 32'(id_valid), 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rs_pc", id_pc, 32'd20);
    do_cycle(1'b1, 1'b0, 1'b1, 32'd30);
    do_cycle(1'b1, 1'b0, 1'b1, 32'd40);
    chk("b2b_bubble", 32'(id_valid), 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("b2b_pc", id_pc, 32'd40);

    // Reset pulsed mid-run at id_pc=7
    do_cycle(1'b1, 1'b0, 1'b1, 32'd5);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("mid_pc7", id_pc, 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", 32'(id_valid), 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_cnt", fetch_cnt, 32'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("restart_pc", id_pc, 32'd0);
    chk("restart_valid", 32'(id_valid), 32'd1);

    // Random traffic against the model, with resets to leave HALT
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (halt_cycles >= 2) begin
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        halt_cycles = 0;
      end else begin
        do_cycle(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 32'($urandom_range(0, 70)));
        halt_cycles = m_halted ? halt_cycles + 1 : 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
